// File: rtl/tracer_array_if.sv
// Readout stream of the ROI trace engine: one accumulated element sum per beat.
// The master drives the words and the slave returns ready.
interface tracer_array_if #(
   parameter int ACC_W = 16,
   parameter int IDX_W = 3
);
   logic             trace_valid;
   logic             trace_ready;
   logic [ACC_W-1:0] trace_data;
   logic [IDX_W-1:0] trace_idx;
   logic             trace_last;

   modport master (
      output trace_valid,
      output trace_data,
      output trace_idx,
      output trace_last,
      input  trace_ready
   );

   modport slave (
      input  trace_valid,
      input  trace_data,
      input  trace_idx,
      input  trace_last,
      output trace_ready
   );
endinterface

// File: rtl/tracer_array.sv
// ROI trace engine: sums windowed pixels around N_ELEM chained centers with saturation,
// then snapshots the sums into a shadow bank that is streamed out while the next frame runs.
module tracer_array #(
   parameter int N_ELEM   = 8,
   parameter int PIX_W    = 8,
   parameter int ACC_W    = 16,
   parameter int ROW_W    = 8,
   parameter int COL_W    = 9,
   parameter int HALF_WIN = 2,
   localparam int IDX_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
   input  logic                 s_axi_aclk,
   input  logic                 s_axi_aresetn,
   input  logic                 center_wr,
   input  logic [ROW_W-1:0]     center_row,
   input  logic [COL_W-1:0]     center_col,
   input  logic                 frame_start,
   input  logic                 frame_end,
   input  logic                 pix_valid,
   input  logic [ROW_W-1:0]     pix_row,
   input  logic [COL_W-1:0]     pix_col,
   input  logic [PIX_W-1:0]     pix_data,
   tracer_array_if.master       trace,
   output logic                 busy,
   output logic                 overrun
);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN1, S_DRAIN2} state_t;

   localparam logic signed [ROW_W:0] HW_R     = (ROW_W+1)'(HALF_WIN);
   localparam logic signed [COL_W:0] HW_C     = (COL_W+1)'(HALF_WIN);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_ELEM - 1);

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   cr_q  [N_ELEM];
   logic [ROW_W-1:0]   cr_d  [N_ELEM];
   logic [COL_W-1:0]   cc_q  [N_ELEM];
   logic [COL_W-1:0]   cc_d  [N_ELEM];
   logic [ACC_W-1:0]   acc_q [N_ELEM];
   logic [ACC_W-1:0]   acc_d [N_ELEM];
   logic [ACC_W-1:0]   shd_q [N_ELEM];
   logic [ACC_W-1:0]   shd_d [N_ELEM];
   logic [N_ELEM-1:0]  hit_q, hit_d;
   logic [PIX_W-1:0]   data_q, data_d;
   logic               rd_active_q, rd_active_d;
   logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
   logic               overrun_q, overrun_d;

   logic clear_acc, accept, shift_en, snap, snap_take;

   assign clear_acc = (state_q == S_IDLE) && frame_start;
   assign accept    = (state_q == S_ACCUM) && pix_valid;
   assign shift_en  = (state_q == S_IDLE) && center_wr;
   assign snap      = (state_q == S_DRAIN2);
   assign snap_take = snap && !rd_active_q;
   assign data_d    = pix_data;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (frame_start) state_d = S_ACCUM;
         S_ACCUM:  if (frame_end)   state_d = S_DRAIN1;
         S_DRAIN1: state_d = S_DRAIN2;
         S_DRAIN2: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Differences are one bit wider than the coordinates so edge pixels never wrap into a window.
   genvar gi;
   generate
      for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
         logic signed [ROW_W:0] dr;
         logic signed [COL_W:0] dc;
         logic [ACC_W:0]        sum;

         assign dr  = $signed({1'b0, pix_row}) - $signed({1'b0, cr_q[gi]});
         assign dc  = $signed({1'b0, pix_col}) - $signed({1'b0, cc_q[gi]});
         assign hit_d[gi] = accept && (dr >= -HW_R) && (dr <= HW_R)
                                   && (dc >= -HW_C) && (dc <= HW_C);
         assign sum = {1'b0, acc_q[gi]} + {{(ACC_W+1-PIX_W){1'b0}}, data_q};
         assign acc_d[gi] = clear_acc  ? '0 :
                            hit_q[gi]  ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) :
                                         acc_q[gi];
         assign shd_d[gi] = snap_take ? acc_q[gi] : shd_q[gi];

         if (gi == 0) begin : g_head
            assign cr_d[gi] = shift_en ? center_row : cr_q[gi];
            assign cc_d[gi] = shift_en ? center_col : cc_q[gi];
         end else begin : g_body
            assign cr_d[gi] = shift_en ? cr_q[gi-1] : cr_q[gi];
            assign cc_d[gi] = shift_en ? cc_q[gi-1] : cc_q[gi];
         end
      end
   endgenerate

   // A snapshot arriving while a readout is in flight is dropped, never merged.
   always_comb begin
      rd_active_d = rd_active_q;
      rd_idx_d    = rd_idx_q;
      overrun_d   = overrun_q;
      if (clear_acc) overrun_d = 1'b0;
      if (rd_active_q && trace.trace_ready) begin
         if (rd_idx_q == LAST_IDX) begin
            rd_active_d = 1'b0;
            rd_idx_d    = '0;
         end else begin
            rd_idx_d = IDX_W'(rd_idx_q + 1'b1);
         end
      end
      if (snap) begin
         if (rd_active_q) begin
            overrun_d = 1'b1;
         end else begin
            rd_active_d = 1'b1;
            rd_idx_d    = '0;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q     <= S_IDLE;
         hit_q       <= '0;
         data_q      <= '0;
         rd_active_q <= 1'b0;
         rd_idx_q    <= '0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < N_ELEM; k++) begin
            cr_q[k]  <= '0;
            cc_q[k]  <= '0;
            acc_q[k] <= '0;
            shd_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         hit_q       <= hit_d;
         data_q      <= data_d;
         rd_active_q <= rd_active_d;
         rd_idx_q    <= rd_idx_d;
         overrun_q   <= overrun_d;
         for (int k = 0; k < N_ELEM; k++) begin
            cr_q[k]  <= cr_d[k];
            cc_q[k]  <= cc_d[k];
            acc_q[k] <= acc_d[k];
            shd_q[k] <= shd_d[k];
         end
      end
   end

   assign trace.trace_valid = rd_active_q;
   assign trace.trace_data  = shd_q[rd_idx_q];
   assign trace.trace_idx   = rd_idx_q;
   assign trace.trace_last  = rd_active_q && (rd_idx_q == LAST_IDX);
   assign busy              = (state_q != S_IDLE);
   assign overrun           = overrun_q;
endmodule

// File: tb/tb_tracer_array.sv
// Scoreboard bench for tracer_array: an integer window model queues the expected words
// per frame and a monitor pops them as the readout port delivers them.
module tb_tracer_array;
   localparam int NE  = 8;
   localparam int AW  = 10;
   localparam int SAT = (1 << AW) - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       center_wr, frame_start, frame_end, pix_valid;
   logic [7:0] center_row, pix_row, pix_data;
   logic [8:0] center_col, pix_col;
   logic       busy, overrun;

   tracer_array_if #(.ACC_W(AW), .IDX_W(3)) tr ();

   tracer_array #(.N_ELEM(NE), .ACC_W(AW), .HALF_WIN(2)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .center_wr     (center_wr),
      .center_row    (center_row),
      .center_col    (center_col),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .pix_valid     (pix_valid),
      .pix_row       (pix_row),
      .pix_col       (pix_col),
      .pix_data      (pix_data),
      .trace         (tr),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; int data; int last; } exp_t;
   exp_t sb[$];
   int   pq_r[$], pq_c[$], pq_d[$];
   int   m_cr[NE], m_cc[NE];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected();
      for (int k = 0; k < NE; k++) begin
         exp_t e;
         int   s = 0;
         for (int i = 0; i < pq_r.size(); i++)
            if (iabs(pq_r[i] - m_cr[k]) <= 2 && iabs(pq_c[i] - m_cc[k]) <= 2) begin
               s += pq_d[i];
               if (s > SAT) s = SAT;
            end
         e.idx = k; e.data = s; e.last = (k == NE - 1);
         sb.push_back(e);
      end
   endtask

   task automatic add_pix(input int r, input int c, input int d);
      pq_r.push_back(r); pq_c.push_back(c); pq_d.push_back(d);
   endtask

   task automatic load_center(input int r, input int c);
      center_wr = 1'b1; center_row = 8'(r); center_col = 9'(c);
      tick();
      center_wr = 1'b0;
      for (int k = NE - 1; k > 0; k--) begin
         m_cr[k] = m_cr[k-1]; m_cc[k] = m_cc[k-1];
      end
      m_cr[0] = r; m_cc[0] = c;
   endtask

   // Runs one frame from the queued pixels; the last pixel shares its cycle with frame_end.
   task automatic run_frame(input bit push, input bit wr_during);
      int n;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_val("ovr_clr", overrun, 0);
      check_val("busy_acc", busy, 1);
      if (push) push_expected();
      n = pq_r.size();
      if (wr_during) begin
         center_wr = 1'b1; center_row = 8'd5; center_col = 9'd5;
      end
      if (n == 0) begin
         frame_end = 1'b1;
         tick();
      end else begin
         for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_row = 8'(pq_r[i]); pix_col = 9'(pq_c[i]); pix_data = 8'(pq_d[i]);
            frame_end = (i == n - 1);
            tick();
         end
      end
      frame_end = 1'b0; pix_valid = 1'b0; center_wr = 1'b0;
      pq_r.delete(); pq_c.delete(); pq_d.delete();
      check_val("busy_d1", busy, 1);
      tick();
      check_val("busy_d2", busy, 1);
      tick();
      check_val("busy_done", busy, 0);
      if (push) check_val("valid_start", tr.trace_valid, 1);
   endtask

   task automatic drain();
      int cnt = 0;
      tr.trace_ready = 1'b1;
      while (sb.size() > 0 && cnt < 200) begin
         tick();
         cnt++;
      end
      if (sb.size() != 0) begin
         check_val("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      check_val("valid_drop", tr.trace_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_valid"}, tr.trace_valid, 0);
      check_val({tag, "_data"},  tr.trace_data, 0);
      check_val({tag, "_idx"},   tr.trace_idx, 0);
      check_val({tag, "_last"},  tr.trace_last, 0);
      check_val({tag, "_busy"},  busy, 0);
      check_val({tag, "_ovr"},   overrun, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && tr.trace_valid) begin
         if (sb.size() == 0) begin
            check_val("spurious_valid", tr.trace_valid, 0);
         end else begin
            check_val("word_idx",  tr.trace_idx,  sb[0].idx);
            check_val("word_data", tr.trace_data, sb[0].data);
            check_val("word_last", tr.trace_last, sb[0].last);
            if (tr.trace_ready) begin
               $display("word idx=%0d data=%0d last=%0d", tr.trace_idx, tr.trace_data, tr.trace_last);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      center_wr = 1'b0; center_row = '0; center_col = '0;
      frame_start = 1'b0; frame_end = 1'b0;
      pix_valid = 1'b0; pix_row = '0; pix_col = '0; pix_data = '0;
      tr.trace_ready = 1'b1;
      for (int k = 0; k < NE; k++) begin m_cr[k] = 0; m_cc[k] = 0; end
      repeat (2) tick();
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single pixel with overlapping windows
      for (int k = NE - 1; k >= 0; k--) load_center(10 + k, 20 + k);
      add_pix(10, 20, 5);
      run_frame(1'b1, 1'b0);
      drain();

      // Edge clipping, no wrap, saturation
      for (int k = 0; k < NE - 2; k++) load_center(200, 300);
      load_center(100, 100);
      load_center(1, 1);
      add_pix(0, 0, 1); add_pix(3, 3, 1); add_pix(4, 3, 1);
      add_pix(255, 0, 1); add_pix(0, 511, 1);
      for (int i = 0; i < 10; i++) add_pix(100, 100, 255);
      run_frame(1'b1, 1'b0);
      drain();
      add_pix(100, 100, 7);
      run_frame(1'b1, 1'b0);
      drain();

      // Backpressure: 5 stalled cycles then alternating ready
      add_pix(2, 2, 6); add_pix(101, 99, 3);
      tr.trace_ready = 1'b0;
      run_frame(1'b1, 1'b0);
      repeat (5) tick();
      for (int cnt = 0; sb.size() > 0 && cnt < 100; cnt++) begin
         tr.trace_ready = ~tr.trace_ready;
         tick();
      end
      check_val("bp_empty", sb.size(), 0);
      check_val("bp_valid_drop", tr.trace_valid, 0);
      tr.trace_ready = 1'b1;

      // Overrun: second snapshot dropped while first readout stalls
      tr.trace_ready = 1'b0;
      add_pix(1, 1, 4);
      run_frame(1'b1, 1'b0);
      add_pix(100, 100, 9);
      run_frame(1'b0, 1'b0);
      check_val("ovr_set", overrun, 1);
      drain();
      check_val("ovr_sticky", overrun, 1);
      run_frame(1'b1, 1'b0);
      drain();

      // center_wr during accumulation leaves the chain alone
      add_pix(100, 100, 9); add_pix(1, 2, 2);
      run_frame(1'b1, 1'b1);
      drain();

      // frame_start with frame_end in IDLE, then reset mid-accumulation
      frame_start = 1'b1; frame_end = 1'b1;
      tick();
      frame_start = 1'b0; frame_end = 1'b0;
      check_val("both_busy", busy, 1);
      pix_valid = 1'b1; pix_row = 8'd1; pix_col = 9'd1; pix_data = 8'd50;
      repeat (5) tick();
      check_val("both_busy_hold", busy, 1);
      check_val("both_no_valid", tr.trace_valid, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      pix_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NE; k++) begin m_cr[k] = 0; m_cc[k] = 0; end
      tick();

      // Centers cleared by reset: every element sees pixels near the origin
      add_pix(0, 0, 3); add_pix(2, 1, 4);
      run_frame(1'b1, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/tracer_array.md
# tracer_array

Parametrised ROI trace engine for the CImgTracer datapath. It holds `N_ELEM` neuron centers loaded through a serial chain and accumulates enhanced, downsampled pixels that fall inside a square window around each center, with saturation. At frame end it snapshots all sums into a shadow bank and streams them out over a valid/ready port, so the next frame can accumulate during readout. It sits between the enhanced-image downsampler and the trace result FIFO/AXI readback.

## Interface
Parameters:
- `N_ELEM`, 8, number of tracer elements (≥1)
- `PIX_W`, 8, pixel data width
- `ACC_W`, 16, accumulator width (≥ `PIX_W`)
- `ROW_W`, 8, row coordinate width
- `COL_W`, 9, column coordinate width
- `HALF_WIN`, 2, window half-size; the window is (2·`HALF_WIN`+1)² pixels

Ports (one clock; reset is asynchronous and active-low):
- `s_axi_aclk`  in  1  clock
- `s_axi_aresetn`  in  1  async active-low reset
- `center_wr`  in  1  shift a center into the chain
- `center_row`  in  `ROW_W`  center row
- `center_col`  in  `COL_W`  center column
- `frame_start`  in  1  start accumulation
- `frame_end`  in  1  end accumulation
- `pix_valid`  in  1  pixel strobe
- `pix_row`  in  `ROW_W`  pixel row
- `pix_col`  in  `COL_W`  pixel column
- `pix_data`  in  `PIX_W`  pixel value, unsigned
- `trace_valid`  out  1  readout word valid
- `trace_ready`  in  1  downstream accept
- `trace_data`  out  `ACC_W`  element sum
- `trace_idx`  out  clog2(`N_ELEM`), min 1  element index
- `trace_last`  out  1  final word of the frame
- `busy`  out  1  accumulator FSM not in IDLE
- `overrun`  out  1  sticky flag: a snapshot was dropped

## Operation
- **Center chain.** On `center_wr` in IDLE, centers shift: element k+1 takes element k, and element 0 takes the input. After `N_ELEM` writes, the first center written is held in element `N_ELEM`-1. `center_wr` outside IDLE is ignored. Reset clears all centers to 0.
- **Accumulator FSM states:** IDLE, ACCUM, DRAIN1, DRAIN2.
  - IDLE → ACCUM on `frame_start`. That edge clears all accumulators and `overrun`.
  - ACCUM → DRAIN1 on `frame_end`.
  - DRAIN1 → DRAIN2, then DRAIN2 → IDLE. The snapshot is attempted at the DRAIN2 edge.
  - `frame_start` outside IDLE is ignored.
  - `frame_start` and `frame_end` together in IDLE: go to ACCUM only, and `frame_end` is ignored.
- **Pixel acceptance.** Pixels are accepted only in ACCUM, including the cycle in which `frame_end` is asserted.
- **Window test.** The test is per element and uses ROW_W+1 / COL_W+1 signed differences, so there is no wrap-around: |`pix_row`−cr| ≤ `HALF_WIN` and |`pix_col`−cc| ≤ `HALF_WIN`.
  - Windows may overlap; one pixel can add to several elements.
  - A window clipped at the image edge simply gets fewer pixels.
- **Accumulation.** Each element computes acc + zero-extended `pix_data` and clamps at 2^`ACC_W`−1. The clamped value stays there until the next `frame_start`.
- **Snapshot and readout.**
  - At the DRAIN2 edge, if the reader is idle, all accumulators copy into the shadow bank and the readout starts.
  - If the reader is still busy, the snapshot is dropped, `overrun` sets, and the current readout continues unaffected.
  - Readout emits shadow words in order idx 0 … `N_ELEM`−1. `trace_last` is asserted with idx `N_ELEM`−1.
  - The word advances on `trace_valid` & `trace_ready`. `trace_data`, `trace_idx` and `trace_last` hold stable while valid is high and ready is low.
  - After the last word is accepted, `trace_valid` drops the next cycle.
- **Independence.** Accumulation of the next frame may run in parallel with readout.
- **Reset mid-operation.** Asynchronous reset aborts everything. On reset: FSM to IDLE, readout idle, all accumulators, shadows and centers cleared.

## Timing
- Reset values: `trace_valid`=0, `trace_data`=0, `trace_idx`=0, `trace_last`=0, `busy`=0, `overrun`=0.
- Pixel pipeline has two stages:
  - Window-hit flags and data are registered at the edge ending cycle t.
  - The accumulator is updated at the edge ending t+1.
- With `frame_end` at cycle t:
  - DRAIN1 at t+1, DRAIN2 at t+2, snapshot at the edge ending t+2.
  - `trace_valid`=1 from cycle t+3.
  - `busy` deasserts at t+3.
- Readout throughput is one word per cycle under continuous `trace_ready`, so `N_ELEM` cycles per frame.
- Minimum frame period without overrun is `N_ELEM`+3 cycles after `frame_end` under full ready.

## Test plan
- **Single-pixel inclusion.** N_ELEM=8, HALF_WIN=2. Load centers (10,20)…(10+7,20+7). Drive one pixel at (10,20) with data 5.
  - Required: idx for center (10,20) reads 5.
  - Required: center (11,21) also reads 5 (overlap).
  - Required: centers ≥(13,23) read 0.
- **Window boundary and edge clipping.** Center (1,1), pixels at (0,0), (3,3), (4,3), each with data 1.
  - Required: the sum is 2, i.e. (4,3) is excluded and there is no wrap.
- **Saturation.** ACC_W=10, 10 pixels of 255 in one window.
  - Required: the sum is 1023.
  - Required: the next frame starts from 0.
- **Backpressure.** Hold `trace_ready` low for 5 cycles after `trace_valid`, then toggle it 1/0.
  - Required: the words stay stable while stalled.
  - Required: idx sequence is 0…7, with `trace_last` only on 7.
  - Required: `trace_valid` is 0 after the final handshake.
- **Overrun.** Keep `trace_ready`=0 and run a second frame to `frame_end`.
  - Required: `overrun`=1.
  - Required: the first frame's data is still output intact.
  - Required: the next `frame_start` clears `overrun`.
- **Reset and ignored inputs.**
  - Assert reset mid-ACCUM → all outputs go to reset values at once.
  - `center_wr` during ACCUM → no change to the centers.
  - `frame_start` and `frame_end` together in IDLE → `busy`=1, and no readout is produced.
